seq_shifter: RTL and testbench
==============================

# seq_shifter

Multi-cycle, parametrised shifter that replaces the fixed single-purpose combinational left-shift used in the datapath. It accepts an operand, a shift amount and a mode through a start/done handshake, then shifts one bit position per clock. The result is held on `out` until the next operation completes. It sits beside the ALU as the shift unit and trades latency for area, since it needs no barrel network.

## Interface
- `WIDTH`, default 32: operand/result width. Must be a power of 2 and at least 2.
- `SHAMT_W`: derived localparam, $clog2(WIDTH), giving the shift-amount width. It is not overridable.
- `clk`  in  1: the single clock. All state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: request a new operation. It is sampled only in IDLE.
- `mode`  in  2: shift mode.
  - 00 SLL
  - 01 SRL
  - 10 SRA
  - 11 ROR (see Configuration)
- `shamt`  in  SHAMT_W: shift amount, 0..WIDTH-1.
- `in`  in  WIDTH: operand.
- `out`  out  WIDTH: registered result.
- `busy`  out  1: high while in SHIFT.
- `done`  out  1: one-cycle pulse, high while in DONE, marking `out` valid and new.

## Operation
- **States:** IDLE, SHIFT, DONE.
- **IDLE:**
  - If `start` is high on an edge, capture `in` into the working register, `shamt` into the counter and `mode` into the mode register, then go to SHIFT.
  - Otherwise stay in IDLE.
- **SHIFT:** on each edge:
  - If the counter is 0, copy the working register to `out` and go to DONE.
  - Otherwise shift the working register by one position per the latched mode and decrement the counter.
- **DONE:** go to IDLE on the next edge unconditionally.
- **Per-step shift rules:**
  - SLL: shift left, zero-fill bit 0.
  - SRL: shift right, zero-fill the MSB.
  - SRA: shift right, refill the MSB with the current MSB. Repeated steps therefore sign-extend.
  - ROR: bit 0 moves to the MSB.
- `start` in SHIFT or DONE is ignored and dropped, not queued.
- Changes to `in`, `shamt` or `mode` after capture have no effect on the operation in flight.
- `out` changes only on entry to DONE or on reset. It holds its value through IDLE and SHIFT.
- **Reset:** takes priority over every transition. Reset in any state, including mid-SHIFT:
  - aborts the operation;
  - state goes to IDLE;
  - `out` = 0, `busy` = 0, `done` = 0;
  - the counter and working register are cleared.

## Timing
- **Reset values:** `out` = 0, `busy` = 0, `done` = 0, state IDLE.
- **Latency:** with the capture edge as edge 0, `done` is high in the cycle after edge `shamt`+1, and `out` is valid from that cycle on.
  - shamt = 0: `done` after edge 1, `out` = `in`.
  - shamt = WIDTH-1: `done` after edge WIDTH.
- **`busy`:** high from after edge 0 through the cycle before DONE, i.e. `shamt`+1 cycles. It is low in DONE and IDLE.
- **`done`:** exactly one cycle wide.
- **Throughput:** the earliest next `start` is accepted on edge `shamt`+3, the first IDLE cycle. Minimum issue interval is `shamt`+3 cycles.
- There is no combinational path from any input to any output.

## Configuration
- **Macro `SEQ_SHIFTER_ROTATE_EN`.**
- **Defined:** mode 11 performs ROR as above.
- **Undefined:**
  - No rotate logic is built.
  - Mode 11 leaves the working register unchanged at every step, so the result is `out` = `in`.
  - The handshake and latency are identical to the other modes: `done` after edge `shamt`+1.

## Test plan
- **Left shift:** `in`=126, mode SLL, shamt=2 -> `done` after edge 3, `out`=504, `busy` high for 3 cycles.
- **Arithmetic vs logical right shift:**
  - `in`=0x80000000, mode SRA, shamt=31 -> `out`=0xFFFFFFFF after edge 32.
  - Same operand, mode SRL -> `out`=0x00000001.
- **Zero shift and rotate:**
  - `in`=0xDEADBEEF, shamt=0, mode SLL -> `out`=0xDEADBEEF after edge 1.
  - `in`=0x00000001, mode ROR, shamt=1: with the macro -> `out`=0x80000000; without it -> `out`=0x00000001.
- **Start while busy:** `start` re-asserted with `in`=5, shamt=1 while an SLL of 3 by 4 is in SHIFT -> only `out`=48 is produced, `done` pulses once, and the second request is dropped.
- **Reset mid-operation:** `reset` asserted on edge 2 of a shamt=10 operation -> after that edge `out`=0, `busy`=0, `done`=0. A subsequent start with 1, SLL, shamt=3 -> `out`=8 after edge 4.
- **Width parameter:** with WIDTH=8, `in`=0x81, mode SRA, shamt=7 -> `out`=0xFF after edge 8.

Source files
------------

// File: rtl/seq_shifter.sv
// -----------------------------------------------------------------------------
// seq_shifter
//
// Multi-cycle shift unit. It captures an operand, shift amount and mode on a
// start request, then moves the operand one bit position per clock. The result
// is registered on `out` and held until the next operation completes. It has
// no barrel network: latency grows with the shift amount.
//
// Parameters:
//   WIDTH    operand/result width (power of 2, >= 2), default 32
//   SHAMT_W  derived, $clog2(WIDTH); not overridable
//
// Ports:
//   clk    in   1        single clock, rising edge
//   reset  in   1        synchronous active-high reset
//   start  in   1        request a new operation (sampled only in IDLE)
//   mode   in   2        00 SLL, 01 SRL, 10 SRA, 11 ROR
//   shamt  in   SHAMT_W  shift amount, 0..WIDTH-1
//   in     in   WIDTH    operand
//   out    out  WIDTH    registered result
//   busy   out  1        high while shifting
//   done   out  1        one-cycle pulse when `out` holds a new result
//
// Configuration macro:
//   SEQ_SHIFTER_ROTATE_EN  when defined, mode 11 rotates right by one bit per
//                          step; when undefined, no rotate logic is built and
//                          mode 11 passes the operand through unchanged.
// -----------------------------------------------------------------------------
module seq_shifter #(
  parameter  int WIDTH   = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   in,
  output logic [WIDTH-1:0]   out,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;

  logic [1:0]         state_reg, state_next;
  logic [WIDTH-1:0]   work_reg,  work_next;
  logic [SHAMT_W-1:0] cnt_reg,   cnt_next;
  logic [1:0]         mode_reg,  mode_next;
  logic [WIDTH-1:0]   out_reg,   out_next;

  // One-position shifted copies of the working register, built bit by bit.
  logic [WIDTH-1:0] sll_val;
  logic [WIDTH-1:0] srl_val;
  logic [WIDTH-1:0] sra_val;
`ifdef SEQ_SHIFTER_ROTATE_EN
  logic [WIDTH-1:0] ror_val;
`endif
  logic [WIDTH-1:0] step_val;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (gi == 0) begin : g_lsb
        assign sll_val[gi] = 1'b0;
      end else begin : g_lsb_n
        assign sll_val[gi] = work_reg[gi-1];
      end

      if (gi == WIDTH-1) begin : g_msb
        assign srl_val[gi] = 1'b0;
        // SRA keeps the sign bit, so repeated steps sign-extend.
        assign sra_val[gi] = work_reg[WIDTH-1];
`ifdef SEQ_SHIFTER_ROTATE_EN
        assign ror_val[gi] = work_reg[0];
`endif
      end else begin : g_msb_n
        assign srl_val[gi] = work_reg[gi+1];
        assign sra_val[gi] = work_reg[gi+1];
`ifdef SEQ_SHIFTER_ROTATE_EN
        assign ror_val[gi] = work_reg[gi+1];
`endif
      end
    end
  endgenerate

  always_comb begin
    step_val = work_reg;
    case (mode_reg)
      MODE_SLL: step_val = sll_val;
      MODE_SRL: step_val = srl_val;
      MODE_SRA: step_val = sra_val;
`ifdef SEQ_SHIFTER_ROTATE_EN
      default:  step_val = ror_val;
`else
      // Without the rotate option, mode 11 still walks through the same
      // number of steps but leaves the operand untouched.
      default:  step_val = work_reg;
`endif
    endcase
  end

  always_comb begin
    state_next = state_reg;
    work_next  = work_reg;
    cnt_next   = cnt_reg;
    mode_next  = mode_reg;
    out_next   = out_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          work_next  = in;
          cnt_next   = shamt;
          mode_next  = mode;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        // The counter reaching zero costs one extra cycle; that cycle
        // publishes the result, which keeps shamt=0 on the same path.
        if (cnt_reg == '0) begin
          out_next   = work_reg;
          state_next = DONE;
        end else begin
          work_next = step_val;
          cnt_next  = cnt_reg - SHAMT_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      work_reg  <= '0;
      cnt_reg   <= '0;
      mode_reg  <= '0;
      out_reg   <= '0;
    end else begin
      state_reg <= state_next;
      work_reg  <= work_next;
      cnt_reg   <= cnt_next;
      mode_reg  <= mode_next;
      out_reg   <= out_next;
    end
  end

  // All outputs are decoded from registers only.
  assign out  = out_reg;
  assign busy = (state_reg == SHIFT);
  assign done = (state_reg == DONE);

endmodule

// File: tb/tb_seq_shifter.sv
// -----------------------------------------------------------------------------
// tb_seq_shifter
//
// Directed test of seq_shifter: a 32-bit instance for the main cases and an
// 8-bit instance for the width parameter. Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  mode;
  logic [4:0]  shamt;
  logic [31:0] in_v;
  logic [31:0] out_v;
  logic        busy;
  logic        done;

  logic        start8;
  logic [1:0]  mode8;
  logic [2:0]  shamt8;
  logic [7:0]  in8;
  logic [7:0]  out8;
  logic        busy8;
  logic        done8;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_exp;

  always #5 clk = ~clk;

  seq_shifter #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .shamt(shamt),
    .in(in_v), .out(out_v), .busy(busy), .done(done)
  );

  seq_shifter #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .mode(mode8), .shamt(shamt8),
    .in(in8), .out(out8), .busy(busy8), .done(done8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      $display("check %s obs=%h exp=%h ok", tag, obs, exp);
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete operation on the 32-bit instance. Inputs are scrambled right
  // after the capture edge to confirm they no longer matter.
  task automatic run_op(input string tag, input logic [1:0] m, input logic [31:0] a,
                        input logic [4:0] s, input logic [31:0] exp);
    int   e;
    int   busy_cnt;
    logic hold_ok;
    @(negedge clk);
    start = 1'b1; mode = m; shamt = s; in_v = a;
    @(negedge clk);               // after capture edge 0
    start = 1'b0; mode = ~m; shamt = ~s; in_v = ~a;
    e = 0; busy_cnt = 0; hold_ok = 1'b1;
    while (done !== 1'b1 && e < 100) begin
      if (busy === 1'b1) busy_cnt++;
      if (out_v !== last_exp) hold_ok = 1'b0;
      @(negedge clk);
      e++;
    end
    chk({tag, "_latency"}, e, s + 1);
    chk({tag, "_busycyc"}, busy_cnt, s + 1);
    chk({tag, "_hold"}, {31'd0, hold_ok}, 32'd1);
    chk({tag, "_out"}, out_v, exp);
    chk({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk({tag, "_done_width"}, {31'd0, done}, 32'd0);
    last_exp = exp;
  endtask

  initial begin
    int   e;
    int   done_cnt;
    logic [31:0] ror_exp1;
    logic [31:0] ror_exp2;
`ifdef SEQ_SHIFTER_ROTATE_EN
    ror_exp1 = 32'h8000_0000;
    ror_exp2 = 32'h7812_3456;
`else
    ror_exp1 = 32'h0000_0001;
    ror_exp2 = 32'h1234_5678;
`endif
    reset = 1'b1; start = 1'b0; mode = 2'b00; shamt = '0; in_v = '0;
    start8 = 1'b0; mode8 = 2'b00; shamt8 = '0; in8 = '0;
    repeat (3) @(negedge clk);
    chk("reset_out", out_v, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    last_exp = 32'd0;

    run_op("sll_126_2",   2'b00, 32'd126,        5'd2,  32'd504);
    run_op("sra_msb_31",  2'b10, 32'h8000_0000,  5'd31, 32'hFFFF_FFFF);
    run_op("srl_msb_31",  2'b01, 32'h8000_0000,  5'd31, 32'h0000_0001);
    run_op("sll_zero",    2'b00, 32'hDEAD_BEEF,  5'd0,  32'hDEAD_BEEF);
    run_op("ror_1_1",     2'b11, 32'h0000_0001,  5'd1,  ror_exp1);
    run_op("ror_8",       2'b11, 32'h1234_5678,  5'd8,  ror_exp2);
    run_op("sra_pos_4",   2'b10, 32'h4000_0000,  5'd4,  32'h0400_0000);
    run_op("sll_3_31",    2'b00, 32'h0000_0003,  5'd31, 32'h8000_0000);

    // Start while busy: second request must be dropped.
    @(negedge clk);
    start = 1'b1; mode = 2'b00; shamt = 5'd4; in_v = 32'd3;
    @(negedge clk);
    start = 1'b0;
    e = 0; done_cnt = 0;
    while (e < 12) begin
      if (e == 1) begin start = 1'b1; in_v = 32'd5; shamt = 5'd1; end
      if (e == 2) start = 1'b0;
      if (done === 1'b1) begin
        done_cnt++;
        chk("busy_start_latency", e, 32'd5);
        chk("busy_start_out", out_v, 32'd48);
      end
      @(negedge clk);
      e++;
    end
    chk("busy_start_done_count", done_cnt, 32'd1);
    chk("busy_start_out_final", out_v, 32'd48);
    chk("busy_start_idle_busy", {31'd0, busy}, 32'd0);

    // Reset in the middle of a shamt=10 operation, sampled on edge 2.
    @(negedge clk);
    start = 1'b1; mode = 2'b00; shamt = 5'd10; in_v = 32'h0000_00FF;
    @(negedge clk);               // after edge 0
    start = 1'b0;
    @(negedge clk);               // after edge 1
    reset = 1'b1;
    @(negedge clk);               // after edge 2
    chk("midreset_out", out_v, 32'd0);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    last_exp = 32'd0;
    run_op("after_reset", 2'b00, 32'd1, 5'd3, 32'd8);

    // Width parameter: 8-bit instance.
    @(negedge clk);
    start8 = 1'b1; mode8 = 2'b10; shamt8 = 3'd7; in8 = 8'h81;
    @(negedge clk);
    start8 = 1'b0; in8 = 8'h00; mode8 = 2'b00;
    e = 0;
    while (done8 !== 1'b1 && e < 100) begin
      @(negedge clk);
      e++;
    end
    chk("w8_sra_latency", e, 32'd8);
    chk("w8_sra_out", {24'd0, out8}, 32'h0000_00FF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
